// File: rtl/fpga_clock_step_ctrl.sv
// Run/halt/single-step sequencer producing the registered enable for fpga_clock_gate.
// Also counts gated cycles (cycles with data_next=1) for host readback.
module fpga_clock_step_ctrl #(
    parameter int CNT_W = 32,
    parameter int CYC_W = 64
) (
    input  logic             soc_clk_i,
    input  logic             rstn,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [CNT_W-1:0] cmd_arg,
    input  logic             abort_i,
    input  logic             buf_full_i,
    input  logic             trap_i,
    output logic             data_next,
    output logic [1:0]       state_o,
    output logic             step_done,
    output logic [CYC_W-1:0] gated_cycles_o
);

    typedef enum logic [1:0] {
        ST_HALT    = 2'd0,
        ST_RUN     = 2'd1,
        ST_STEP    = 2'd2,
        ST_TRAPPED = 2'd3
    } state_t;

    localparam logic [1:0] OP_HALT  = 2'd0;
    localparam logic [1:0] OP_RUN   = 2'd1;
    localparam logic [1:0] OP_STEP  = 2'd2;
    localparam logic [1:0] OP_CLEAR = 2'd3;

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] remaining_reg, remaining_next;
    logic             data_next_reg, data_next_next;
    logic             step_done_reg, step_done_next;
    logic [CYC_W-1:0] gated_cycles_reg;
    logic             cmd_fire;
    logic             gate_ok;
    logic             clear_cnt;

    assign cmd_ready = (state_reg != ST_STEP);
    assign cmd_fire  = cmd_valid & cmd_ready;
    assign gate_ok   = ~buf_full_i & ~trap_i & ~abort_i;
    assign clear_cnt = cmd_fire & (cmd_op == OP_CLEAR);

    always_ff @(posedge soc_clk_i or negedge rstn) begin
        if (!rstn) begin
            state_reg     <= ST_HALT;
            remaining_reg <= '0;
            data_next_reg <= 1'b0;
            step_done_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            remaining_reg <= remaining_next;
            data_next_reg <= data_next_next;
            step_done_reg <= step_done_next;
        end
    end

    // remaining counts enables not yet loaded; the edge loading the last one leaves STEP.
    always_comb begin
        state_next     = state_reg;
        remaining_next = remaining_reg;
        data_next_next = 1'b0;
        step_done_next = 1'b0;
        case (state_reg)
            ST_HALT: begin
                if (cmd_fire && cmd_op == OP_RUN) begin
                    state_next     = ST_RUN;
                    data_next_next = gate_ok;
                end else if (cmd_fire && cmd_op == OP_STEP) begin
                    if (cmd_arg == '0) begin
                        step_done_next = 1'b1;
                    end else if (gate_ok) begin
                        data_next_next = 1'b1;
                        remaining_next = cmd_arg - CNT_W'(1);
                        if (cmd_arg == CNT_W'(1)) begin
                            step_done_next = 1'b1;
                        end else begin
                            state_next = ST_STEP;
                        end
                    end else begin
                        state_next     = ST_STEP;
                        remaining_next = cmd_arg;
                    end
                end
            end
            ST_RUN: begin
                if (trap_i) begin
                    state_next = ST_TRAPPED;
                end else if (cmd_fire && cmd_op == OP_HALT) begin
                    state_next = ST_HALT;
                end else begin
                    data_next_next = gate_ok;
                end
            end
            ST_STEP: begin
                if (trap_i) begin
                    state_next     = ST_TRAPPED;
                    remaining_next = '0;
                end else if (abort_i) begin
                    state_next     = ST_HALT;
                    remaining_next = '0;
                end else if (!buf_full_i && remaining_reg != '0) begin
                    data_next_next = 1'b1;
                    remaining_next = remaining_reg - CNT_W'(1);
                    if (remaining_reg == CNT_W'(1)) begin
                        state_next     = ST_HALT;
                        step_done_next = 1'b1;
                    end
                end
            end
            ST_TRAPPED: begin
                if (clear_cnt) begin
                    state_next = ST_HALT;
                end
            end
            default: state_next = ST_HALT;
        endcase
    end

    // Clear takes precedence over counting an enabled cycle on the same edge.
    always_ff @(posedge soc_clk_i or negedge rstn) begin
        if (!rstn) begin
            gated_cycles_reg <= '0;
        end else if (clear_cnt) begin
            gated_cycles_reg <= '0;
        end else if (data_next_reg) begin
            gated_cycles_reg <= gated_cycles_reg + CYC_W'(1);
        end
    end

    assign data_next      = data_next_reg;
    assign state_o        = state_reg;
    assign step_done      = step_done_reg;
    assign gated_cycles_o = gated_cycles_reg;

endmodule

// File: tb/tb_fpga_clock_step_ctrl.sv
// Directed and randomized checks of fpga_clock_step_ctrl against a step-target/issued-count model.
module tb_fpga_clock_step_ctrl;
    localparam int CNT_W = 32;
    localparam int CYC_W = 64;
    localparam int M_HALT = 0, M_RUN = 1, M_STEP = 2, M_TRAP = 3;

    logic             clk = 1'b0;
    logic             rstn = 1'b1;
    logic             cmd_valid = 1'b0;
    logic             cmd_ready;
    logic [1:0]       cmd_op = 2'd0;
    logic [CNT_W-1:0] cmd_arg = '0;
    logic             abort_i = 1'b0;
    logic             buf_full_i = 1'b0;
    logic             trap_i = 1'b0;
    logic             data_next;
    logic [1:0]       state_o;
    logic             step_done;
    logic [CYC_W-1:0] gated_cycles_o;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: mode, step target vs. enables issued so far, expected outputs.
    int               m_mode;
    longint unsigned  m_target, m_issued;
    bit               m_dn, m_done, m_fired;
    logic [CYC_W-1:0] m_cnt;

    fpga_clock_step_ctrl #(.CNT_W(CNT_W), .CYC_W(CYC_W)) dut (
        .soc_clk_i(clk), .rstn(rstn), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_arg(cmd_arg), .abort_i(abort_i), .buf_full_i(buf_full_i),
        .trap_i(trap_i), .data_next(data_next), .state_o(state_o), .step_done(step_done),
        .gated_cycles_o(gated_cycles_o)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_mode = M_HALT; m_target = 0; m_issued = 0;
        m_dn = 0; m_done = 0; m_fired = 0; m_cnt = '0;
    endtask

    task automatic model_edge();
        bit fire, ok, dn, done;
        logic [CYC_W-1:0] cnt_n;
        fire = cmd_valid && (m_mode != M_STEP);
        ok   = !buf_full_i && !trap_i && !abort_i;
        cnt_n = m_dn ? m_cnt + 1 : m_cnt;
        if (fire && cmd_op == 2'd3) cnt_n = '0;
        dn = 0; done = 0;
        case (m_mode)
            M_HALT: if (fire && cmd_op == 2'd1) begin
                m_mode = M_RUN; dn = ok;
            end else if (fire && cmd_op == 2'd2) begin
                if (cmd_arg == 0) done = 1;
                else begin
                    m_target = cmd_arg; m_issued = 0; m_mode = M_STEP;
                    if (ok) begin
                        dn = 1; m_issued = 1;
                        if (m_issued == m_target) begin done = 1; m_mode = M_HALT; end
                    end
                end
            end
            M_RUN: if (trap_i) m_mode = M_TRAP;
                   else if (fire && cmd_op == 2'd0) m_mode = M_HALT;
                   else dn = ok;
            M_STEP: if (trap_i) m_mode = M_TRAP;
                    else if (abort_i) m_mode = M_HALT;
                    else if (!buf_full_i) begin
                        dn = 1; m_issued++;
                        if (m_issued == m_target) begin done = 1; m_mode = M_HALT; end
                    end
            default: if (fire && cmd_op == 2'd3) m_mode = M_HALT;
        endcase
        m_dn = dn; m_done = done; m_cnt = cnt_n; m_fired = fire;
    endtask

    // Advance one clock; returns at the following falling edge.
    task automatic tick();
        @(posedge clk);
        model_edge();
        if (m_fired) $display("cmd op=%0d arg=%0d accepted at %0t", cmd_op, cmd_arg, $time);
        @(negedge clk);
    endtask

    task automatic send(input logic [1:0] op, input logic [CNT_W-1:0] arg);
        cmd_valid = 1'b1; cmd_op = op; cmd_arg = arg;
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic test_reset();
        #2 rstn = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        n_cmp++; if (data_next !== 1'b0) begin n_bad++; $display("FAIL reset_dn: got %b want 0", data_next); end
        n_cmp++; if (state_o !== 2'd0) begin n_bad++; $display("FAIL reset_state: got %0d want 0", state_o); end
        n_cmp++; if (step_done !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b want 0", step_done); end
        n_cmp++; if (gated_cycles_o !== '0) begin n_bad++; $display("FAIL reset_cnt: got %0d want 0", gated_cycles_o); end
        n_cmp++; if (cmd_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready: got %b want 1", cmd_ready); end
        rstn = 1'b1;
        tick();
    endtask

    task automatic test_run_100();
        int en = 0;
        send(2'd1, '0);
        for (int c = 1; c <= 100; c++) begin
            if (data_next === 1'b1) en++;
            if (c < 100) tick();
        end
        send(2'd0, '0);
        n_cmp++; if (en != 100) begin n_bad++; $display("FAIL run_enables: got %0d want 100", en); end
        n_cmp++; if (data_next !== 1'b0) begin n_bad++; $display("FAIL run_halt_dn: got %b want 0", data_next); end
        n_cmp++; if (gated_cycles_o !== 64'd100) begin n_bad++; $display("FAIL run_cnt: got %0d want 100", gated_cycles_o); end
        n_cmp++; if (state_o !== 2'd0) begin n_bad++; $display("FAIL run_state: got %0d want 0", state_o); end
    endtask

    task automatic test_step_stall();
        int en = 0;
        logic [CYC_W-1:0] cnt0 = m_cnt;
        send(2'd2, 32'd5);
        for (int c = 1; c <= 8; c++) begin
            bit want_en = (c <= 2) || (c >= 6);
            n_cmp++; if (data_next !== want_en) begin n_bad++; $display("FAIL stall_dn c%0d: got %b want %b", c, data_next, want_en); end
            n_cmp++; if (step_done !== (c == 8)) begin n_bad++; $display("FAIL stall_done c%0d: got %b want %b", c, step_done, c == 8); end
            if (c < 8) begin
                n_cmp++; if (cmd_ready !== 1'b0) begin n_bad++; $display("FAIL stall_ready c%0d: got %b want 0", c, cmd_ready); end
            end
            if (data_next === 1'b1) en++;
            buf_full_i = (c >= 2 && c <= 4);
            tick();
        end
        buf_full_i = 1'b0;
        n_cmp++; if (en != 5) begin n_bad++; $display("FAIL stall_enables: got %0d want 5", en); end
        n_cmp++; if (state_o !== 2'd0) begin n_bad++; $display("FAIL stall_state: got %0d want 0", state_o); end
        n_cmp++; if (gated_cycles_o !== cnt0 + 5) begin n_bad++; $display("FAIL stall_cnt: got %0d want %0d", gated_cycles_o, cnt0 + 5); end
    endtask

    task automatic test_step_zero();
        logic [CYC_W-1:0] cnt0 = m_cnt;
        send(2'd2, '0);
        n_cmp++; if (step_done !== 1'b1) begin n_bad++; $display("FAIL zero_done: got %b want 1", step_done); end
        n_cmp++; if (data_next !== 1'b0) begin n_bad++; $display("FAIL zero_dn: got %b want 0", data_next); end
        tick();
        n_cmp++; if (step_done !== 1'b0) begin n_bad++; $display("FAIL zero_done_end: got %b want 0", step_done); end
        n_cmp++; if (gated_cycles_o !== cnt0) begin n_bad++; $display("FAIL zero_cnt: got %0d want %0d", gated_cycles_o, cnt0); end
    endtask

    task automatic test_trap();
        send(2'd1, '0);
        trap_i = 1'b1;
        tick();
        trap_i = 1'b0;
        n_cmp++; if (data_next !== 1'b0) begin n_bad++; $display("FAIL trap_dn: got %b want 0", data_next); end
        n_cmp++; if (state_o !== 2'd3) begin n_bad++; $display("FAIL trap_state: got %0d want 3", state_o); end
        n_cmp++; if (cmd_ready !== 1'b1) begin n_bad++; $display("FAIL trap_ready: got %b want 1", cmd_ready); end
        send(2'd1, '0);
        send(2'd2, 32'd3);
        n_cmp++; if (state_o !== 2'd3 || data_next !== 1'b0) begin n_bad++; $display("FAIL trap_ignore: got state %0d dn %b want 3/0", state_o, data_next); end
        send(2'd3, '0);
        n_cmp++; if (state_o !== 2'd0) begin n_bad++; $display("FAIL trap_clear_state: got %0d want 0", state_o); end
        n_cmp++; if (gated_cycles_o !== '0) begin n_bad++; $display("FAIL trap_clear_cnt: got %0d want 0", gated_cycles_o); end
    endtask

    task automatic test_abort();
        int done_seen = 0;
        send(2'd2, 32'd10);
        for (int c = 1; c <= 9; c++) begin
            n_cmp++; if (data_next !== 1'b1) begin n_bad++; $display("FAIL abort_dn c%0d: got %b want 1", c, data_next); end
            if (step_done === 1'b1) done_seen++;
            abort_i = (c == 9);
            tick();
        end
        abort_i = 1'b0;
        if (step_done === 1'b1) done_seen++;
        n_cmp++; if (done_seen != 0) begin n_bad++; $display("FAIL abort_done: got %0d pulses want 0", done_seen); end
        n_cmp++; if (data_next !== 1'b0) begin n_bad++; $display("FAIL abort_end_dn: got %b want 0", data_next); end
        n_cmp++; if (state_o !== 2'd0) begin n_bad++; $display("FAIL abort_state: got %0d want 0", state_o); end
        n_cmp++; if (gated_cycles_o !== 64'd9) begin n_bad++; $display("FAIL abort_cnt: got %0d want 9", gated_cycles_o); end
        send(2'd2, 32'd10);
        tick();
        trap_i = 1'b1; abort_i = 1'b1;
        tick();
        trap_i = 1'b0; abort_i = 1'b0;
        n_cmp++; if (state_o !== 2'd3 || data_next !== 1'b0) begin n_bad++; $display("FAIL trap_abort: got state %0d dn %b want 3/0", state_o, data_next); end
        send(2'd3, '0);
    endtask

    task automatic test_reset_mid_step();
        int done_seen = 0;
        send(2'd2, 32'd1000);
        repeat (199) tick();
        n_cmp++; if (state_o !== 2'd2 || data_next !== 1'b1) begin n_bad++; $display("FAIL midstep_active: got state %0d dn %b want 2/1", state_o, data_next); end
        #2 rstn = 1'b0;
        model_reset();
        #1;
        n_cmp++; if (data_next !== 1'b0 || step_done !== 1'b0) begin n_bad++; $display("FAIL async_rst_out: got dn %b done %b want 0/0", data_next, step_done); end
        n_cmp++; if (state_o !== 2'd0 || cmd_ready !== 1'b1) begin n_bad++; $display("FAIL async_rst_state: got state %0d ready %b want 0/1", state_o, cmd_ready); end
        n_cmp++; if (gated_cycles_o !== '0) begin n_bad++; $display("FAIL async_rst_cnt: got %0d want 0", gated_cycles_o); end
        @(negedge clk);
        rstn = 1'b1;
        for (int c = 0; c < 5; c++) begin
            tick();
            if (step_done === 1'b1 || data_next === 1'b1) done_seen++;
        end
        n_cmp++; if (done_seen != 0 || state_o !== 2'd0 || gated_cycles_o !== '0) begin
            n_bad++; $display("FAIL post_rst: got activity %0d state %0d cnt %0d want 0/0/0", done_seen, state_o, gated_cycles_o);
        end
    endtask

    task automatic test_wrap();
        force dut.gated_cycles_reg = {CYC_W{1'b1}};
        tick();
        release dut.gated_cycles_reg;
        m_cnt = {CYC_W{1'b1}};
        n_cmp++; if (gated_cycles_o !== {CYC_W{1'b1}}) begin n_bad++; $display("FAIL wrap_preload: got %h want all ones", gated_cycles_o); end
        send(2'd1, '0);
        send(2'd0, '0);
        n_cmp++; if (gated_cycles_o !== '0) begin n_bad++; $display("FAIL wrap: got %h want 0", gated_cycles_o); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 1500; i++) begin
            cmd_valid  = ($urandom % 4) == 0;
            cmd_op     = 2'($urandom % 4);
            cmd_arg    = CNT_W'($urandom_range(0, 6));
            buf_full_i = ($urandom % 5) == 0;
            trap_i     = ($urandom % 60) == 0;
            abort_i    = ($urandom % 25) == 0;
            tick();
            n_cmp++; if (data_next !== m_dn) begin n_bad++; $display("FAIL rnd_dn i%0d: got %b want %b", i, data_next, m_dn); end
            n_cmp++; if (state_o !== 2'(m_mode)) begin n_bad++; $display("FAIL rnd_state i%0d: got %0d want %0d", i, state_o, m_mode); end
            n_cmp++; if (step_done !== m_done) begin n_bad++; $display("FAIL rnd_done i%0d: got %b want %b", i, step_done, m_done); end
            n_cmp++; if (cmd_ready !== (m_mode != M_STEP)) begin n_bad++; $display("FAIL rnd_ready i%0d: got %b want %b", i, cmd_ready, m_mode != M_STEP); end
            n_cmp++; if (gated_cycles_o !== m_cnt) begin n_bad++; $display("FAIL rnd_cnt i%0d: got %0d want %0d", i, gated_cycles_o, m_cnt); end
        end
        cmd_valid = 1'b0; buf_full_i = 1'b0; trap_i = 1'b0; abort_i = 1'b0;
    endtask

    initial begin
        model_reset();
        test_reset();
        test_run_100();
        test_step_stall();
        test_step_zero();
        test_trap();
        test_abort();
        test_reset_mid_step();
        test_wrap();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
